// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: CPU I/D ports and single-port memory bus.
// slave = arbiter side, master = CPU/memory side.
interface mem_arbiter_if;
  logic        i_req_i;
  logic [31:0] i_addr_i;
  logic        i_ack_o;
  logic [31:0] i_data_o;
  logic        i_err_o;
  logic        d_req_i;
  logic        d_we_i;
  logic [3:0]  d_sel_i;
  logic [31:0] d_addr_i;
  logic [31:0] d_wdata_i;
  logic        d_ack_o;
  logic [31:0] d_rdata_o;
  logic        d_err_o;
  logic        mem_ce_o;
  logic        mem_we_o;
  logic [3:0]  mem_sel_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;
  logic        mem_ack_i;
  logic        stall_req_o;

  modport slave (
    input  i_req_i, i_addr_i,
    output i_ack_o, i_data_o, i_err_o,
    input  d_req_i, d_we_i, d_sel_i, d_addr_i, d_wdata_i,
    output d_ack_o, d_rdata_o, d_err_o,
    output mem_ce_o, mem_we_o, mem_sel_o, mem_addr_o, mem_wdata_o,
    input  mem_rdata_i, mem_ack_i,
    output stall_req_o
  );

  modport master (
    output i_req_i, i_addr_i,
    input  i_ack_o, i_data_o, i_err_o,
    output d_req_i, d_we_i, d_sel_i, d_addr_i, d_wdata_i,
    input  d_ack_o, d_rdata_o, d_err_o,
    input  mem_ce_o, mem_we_o, mem_sel_o, mem_addr_o, mem_wdata_o,
    output mem_rdata_i, mem_ack_i,
    input  stall_req_o
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: I/D port arbiter for one unified single-port memory.
// Define ARB_ROUND_ROBIN_EN for round-robin on contention (default D>I).
module mem_arbiter #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY_I,
    BUSY_D,
    DONE
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t      state_q;
  logic [CNT_W-1:0] cnt_q;
  logic        i_ack_q;
  logic        i_err_q;
  logic [31:0] i_data_q;
  logic        d_ack_q;
  logic        d_err_q;
  logic [31:0] d_rdata_q;
  logic        ce_q;
  logic        we_q;
  logic [3:0]  sel_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        tmo;
  logic        grant_d;

  assign tmo = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

`ifdef ARB_ROUND_ROBIN_EN
  logic last_d_q;
  assign grant_d = bus.d_req_i & (~bus.i_req_i | ~last_d_q);
`else
  assign grant_d = bus.d_req_i;
`endif

  assign bus.i_ack_o     = i_ack_q;
  assign bus.i_err_o     = i_err_q;
  assign bus.i_data_o    = i_data_q;
  assign bus.d_ack_o     = d_ack_q;
  assign bus.d_err_o     = d_err_q;
  assign bus.d_rdata_o   = d_rdata_q;
  assign bus.mem_ce_o    = ce_q;
  assign bus.mem_we_o    = we_q;
  assign bus.mem_sel_o   = sel_q;
  assign bus.mem_addr_o  = addr_q;
  assign bus.mem_wdata_o = wdata_q;

  // Stall while a request is pending and not yet acked; quiet in reset.
  assign bus.stall_req_o = rst &
    ((bus.i_req_i & ~i_ack_q) | (bus.d_req_i & ~d_ack_q));

  // Arbitration FSM with registered memory-side and completion outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      i_ack_q   <= 1'b0;
      i_err_q   <= 1'b0;
      i_data_q  <= '0;
      d_ack_q   <= 1'b0;
      d_err_q   <= 1'b0;
      d_rdata_q <= '0;
      ce_q      <= 1'b0;
      we_q      <= 1'b0;
      sel_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last_d_q  <= 1'b1;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (grant_d) begin
            state_q <= BUSY_D;
            ce_q    <= 1'b1;
            we_q    <= bus.d_we_i;
            sel_q   <= bus.d_sel_i;
            addr_q  <= bus.d_addr_i;
            wdata_q <= bus.d_wdata_i;
`ifdef ARB_ROUND_ROBIN_EN
            last_d_q <= 1'b1;
`endif
          end else if (bus.i_req_i) begin
            state_q <= BUSY_I;
            ce_q    <= 1'b1;
            we_q    <= 1'b0;
            sel_q   <= 4'b1111;
            addr_q  <= bus.i_addr_i;
            wdata_q <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_d_q <= 1'b0;
`endif
          end
        end
        BUSY_I, BUSY_D: begin
          cnt_q <= cnt_q + 1'b1;
          if (bus.mem_ack_i || tmo) begin
            state_q <= DONE;
            ce_q    <= 1'b0;
            we_q    <= 1'b0;
            if (state_q == BUSY_I) begin
              i_ack_q  <= 1'b1;
              i_err_q  <= ~bus.mem_ack_i;
              i_data_q <= bus.mem_ack_i ? bus.mem_rdata_i : '0;
            end else begin
              d_ack_q   <= 1'b1;
              d_err_q   <= ~bus.mem_ack_i;
              d_rdata_q <= (bus.mem_ack_i && !we_q) ?
                           bus.mem_rdata_i : '0;
            end
          end
        end
        DONE: begin
          state_q   <= IDLE;
          cnt_q     <= '0;
          i_ack_q   <= 1'b0;
          i_err_q   <= 1'b0;
          i_data_q  <= '0;
          d_ack_q   <= 1'b0;
          d_err_q   <= 1'b0;
          d_rdata_q <= '0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-port unified memory between the CPU instruction-fetch port (I) and data port (D) in the minimal SOPC.
- Sequences each access as request -> memory cycle -> ack, with registered memory-side outputs, a bus timeout and a pipeline stall request to the CPU.
- Sits between `mips` and the memory that replaces the separate `inst_rom` / `data_ram` instances.

Parameters:
- TIMEOUT, 16: max cycles in BUSY without `mem_ack_i` before abort; 0 disables the timeout.
- CNT_W, 5: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  clock; all logic on the rising edge
- rst  in  1  synchronous, active-low reset
- i_req_i  in  1  instruction fetch request; held stable until i_ack_o
- i_addr_i  in  32  fetch byte address
- i_ack_o  out  1  one-cycle fetch completion pulse
- i_data_o  out  32  fetched word; valid while i_ack_o=1
- i_err_o  out  1  fetch aborted by timeout; valid with i_ack_o
- d_req_i  in  1  data request; held stable until d_ack_o
- d_we_i  in  1  1=write, 0=read
- d_sel_i  in  4  byte enables
- d_addr_i  in  32  data byte address
- d_wdata_i  in  32  write data
- d_ack_o  out  1  one-cycle data completion pulse
- d_rdata_o  out  32  read data; valid while d_ack_o=1
- d_err_o  out  1  data access aborted by timeout; valid with d_ack_o
- mem_ce_o  out  1  memory chip enable
- mem_we_o  out  1  memory write enable
- mem_sel_o  out  4  memory byte enables
- mem_addr_o  out  32  memory address
- mem_wdata_o  out  32  memory write data
- mem_rdata_i  in  32  memory read data; sampled when mem_ack_i=1
- mem_ack_i  in  1  memory completion; may arrive in the first BUSY cycle or later
- stall_req_o  out  1  to CPU pipeline control

Behaviour:
- Reset (rst=0 at a clock edge):
  - state=IDLE; all registered outputs 0; timeout counter 0; RR pointer = D.
  - Any in-flight transaction is dropped with no ack and no err.
- States: IDLE, BUSY_I, BUSY_D, DONE.
- IDLE:
  - If d_req_i=1, go to BUSY_D (fixed priority: D over I); else if i_req_i=1, go to BUSY_I; else stay.
  - On entry to BUSY_x, register mem_* from the granted master.
  - I accesses drive mem_we=0 and mem_sel=4'b1111.
- BUSY_x:
  - mem_ce_o=1 and mem_* held constant.
  - Counter increments each cycle.
  - When mem_ack_i=1: go to DONE; register x_ack=1, x_data/x_rdata=mem_rdata_i (writes return 0), x_err=0; mem_ce_o and mem_we_o go to 0.
  - Else if TIMEOUT!=0 and counter==TIMEOUT-1: go to DONE with x_ack=1, x_err=1, data=0.
  - If mem_ack_i and timeout occur in the same cycle, the ack wins and err=0.
- DONE:
  - Ack/err/data outputs are high for exactly this cycle; the next state is always IDLE.
  - Requests are ignored here, because the acked master may still hold req this cycle.
  - Counter cleared.
- mem_ack_i in IDLE or DONE is ignored.
- Latency: req seen at cycle t, mem_ce at t+1, ack at t+1+N where N>=1 is the memory wait. Best case is one access per 3 cycles.
- Outputs i_ack_o and d_ack_o are never high together; the non-granted master's outputs stay 0.
- stall_req_o = (i_req_i & ~i_ack_o) | (d_req_i & ~d_ack_o). This is combinational and is 0 in reset.
- Master protocol violations (changing req fields before ack) are undefined. The arbiter uses the values latched at grant.

Optional Feature:
- Macro ARB_ROUND_ROBIN_EN.
- Defined:
  - A 1-bit pointer records the last-granted master.
  - When both requests are high in IDLE, the master not granted last wins.
  - A single requester is always granted.
  - The pointer updates on each grant and resets to D, so the first contention goes to I.
- Undefined: fixed D-over-I priority; no pointer register.

Test Plan:
- Reset mid-transfer: d read granted, rst=0 during BUSY_D -> next cycle state IDLE, mem_ce_o=0, d_ack_o never pulses, all outputs 0.
- Single fetch, zero-wait memory: i_req_i=1, addr=0x100, mem_ack_i returned in first BUSY cycle with rdata=0x3401ABCD -> mem_ce_o=1 at t+1 with mem_addr_o=0x100, mem_sel_o=4'hF, mem_we_o=0; i_ack_o=1 with i_data_o=0x3401ABCD at t+2, for one cycle only.
- Simultaneous requests (macro undefined): i_req_i=d_req_i=1, d write addr 0x20, sel 4'b0011, data 0xDEADBEEF -> D served first with mem_we_o=1, mem_sel_o=4'b0011, then after DONE and IDLE, I served; stall_req_o=1 until each ack.
- Same as above with ARB_ROUND_ROBIN_EN: two back-to-back contention rounds -> grant order I, D, I, D.
- Timeout: TIMEOUT=16, d read, mem_ack_i held 0 -> d_ack_o=1, d_err_o=1, d_rdata_o=0 exactly 16 cycles after mem_ce_o rises; mem_ce_o drops the same cycle.
- Wait-state memory: mem_ack_i after 3 BUSY cycles -> mem_* stable for all 3 cycles, ack on the 4th; a late mem_ack_i arriving in DONE or IDLE is ignored.
